// File: rtl/pkmc_arb_pkg.sv
// Shared types and constants for the PKMC SRAM arbiter slice.
package pkmc_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    TURN = 2'd2
  } arbState_t;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M0   = 2'b01;
  localparam logic [1:0] GNT_M1   = 2'b10;

  localparam int TIMEOUT_DEFAULT = 15;

endpackage

// File: rtl/pkmc_rr_pick.sv
// Two-input round-robin picker: a lone requester wins, a tie goes to the
// requester that was not granted last (lastGrant = index of previous owner).
module pkmc_rr_pick
  import pkmc_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       lastGrant,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = lastGrant ? GNT_M0 : GNT_M1;
  end

endmodule

// File: rtl/pkmc_sram_arbiter.sv
// Two-master Wishbone arbiter in front of the PKMC SRAM controller, with a
// one-cycle turnaround between transfers and a timeout abort on hung transfers.
module pkmc_sram_arbiter
  import pkmc_arb_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int AW      = 32,
  parameter int DW      = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_cyc_i,
  input  logic          m0_stb_i,
  input  logic          m0_we_i,
  input  logic [AW-1:0] m0_adr_i,
  input  logic [DW-1:0] m0_dat_i,
  input  logic [3:0]    m0_sel_i,
  output logic [DW-1:0] m0_dat_o,
  output logic          m0_ack_o,
  output logic          m0_err_o,
  input  logic          m1_cyc_i,
  input  logic          m1_stb_i,
  input  logic          m1_we_i,
  input  logic [AW-1:0] m1_adr_i,
  input  logic [DW-1:0] m1_dat_i,
  input  logic [3:0]    m1_sel_i,
  output logic [DW-1:0] m1_dat_o,
  output logic          m1_ack_o,
  output logic          m1_err_o,
  output logic          mem_active_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_dat_o,
  output logic [3:0]    mem_sel_o,
  input  logic [DW-1:0] mem_dat_i,
  input  logic          mem_ack_i,
  output logic [1:0]    gnt_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  arbState_t     state, nextState;
  logic [1:0]    grant, nextGrant;
  logic          lastGrant, nextLast;
  logic [CW-1:0] cnt, nextCnt;
  logic [1:0]    req, pick;
  logic          busy, ownReq, timeoutHit, ackHit, errHit;

  assign req        = {m1_cyc_i & m1_stb_i, m0_cyc_i & m0_stb_i};
  assign busy       = (state == BUSY);
  assign ownReq     = |(req & grant);
  assign timeoutHit = (cnt == CW'(TIMEOUT - 1));

  pkmc_rr_pick picker (
    .req       (req),
    .lastGrant (lastGrant),
    .gnt       (pick)
  );

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      grant     <= GNT_NONE;
      lastGrant <= 1'b1;
      cnt       <= '0;
    end else begin
      state     <= nextState;
      grant     <= nextGrant;
      lastGrant <= nextLast;
      cnt       <= nextCnt;
    end
  end

  // NOTE: every output of this block gets a default first, so no path infers a latch.
  always_comb begin
    nextState = state;
    nextGrant = grant;
    nextLast  = lastGrant;
    nextCnt   = '0;
    ackHit    = 1'b0;
    errHit    = 1'b0;
    unique case (state)
      IDLE: begin
        if (|req) begin
          nextGrant = pick;
          nextState = BUSY;
        end
      end
      BUSY: begin
        nextCnt = cnt + 1'b1;
        // Ack beats timeout; a withdrawn request is a silent abort.
        if (mem_ack_i) begin
          ackHit    = 1'b1;
          nextLast  = grant[1];
          nextState = TURN;
        end else if (!ownReq) begin
          nextState = TURN;
        end else if (timeoutHit) begin
          errHit    = 1'b1;
          nextLast  = grant[1];
          nextState = TURN;
        end
      end
      TURN: begin
        nextGrant = GNT_NONE;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  assign m0_ack_o     = ackHit & grant[0];
  assign m1_ack_o     = ackHit & grant[1];
  assign m0_err_o     = errHit & grant[0];
  assign m1_err_o     = errHit & grant[1];
  assign m0_dat_o     = mem_dat_i;
  assign m1_dat_o     = mem_dat_i;
  assign mem_active_o = busy;
  assign gnt_o        = busy ? grant : GNT_NONE;

  always_comb begin
    mem_we_o   = 1'b0;
    mem_addr_o = '0;
    mem_dat_o  = '0;
    mem_sel_o  = '0;
    if (busy) begin
      mem_we_o   = grant[1] ? m1_we_i  : m0_we_i;
      mem_addr_o = grant[1] ? m1_adr_i : m0_adr_i;
      mem_dat_o  = grant[1] ? m1_dat_i : m0_dat_i;
      mem_sel_o  = grant[1] ? m1_sel_i : m0_sel_i;
    end
  end

endmodule

// File: tb/tb_pkmc_sram_arbiter.sv
// Randomized self-checking bench: transaction-level reference model plus a
// stub controller whose ack latency is chosen per transfer.
module tb_pkmc_sram_arbiter;

  localparam int TO = 4;

  typedef struct {
    bit          valid;
    bit          we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
  } xact_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc[2], stb[2], we[2];
  logic [31:0] adr[2], datW[2], dout[2];
  logic [3:0]  sel[2];
  logic        ack[2], err[2];
  logic        mem_active_o, mem_we_o, mem_ack_i;
  logic [31:0] mem_addr_o, mem_dat_o, mem_dat_i;
  logic [3:0]  mem_sel_o;
  logic [1:0]  gnt_o;

  always #5 clk = ~clk;

  pkmc_sram_arbiter #(.TIMEOUT(TO), .AW(32), .DW(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .m0_cyc_i     (cyc[0]),
    .m0_stb_i     (stb[0]),
    .m0_we_i      (we[0]),
    .m0_adr_i     (adr[0]),
    .m0_dat_i     (datW[0]),
    .m0_sel_i     (sel[0]),
    .m0_dat_o     (dout[0]),
    .m0_ack_o     (ack[0]),
    .m0_err_o     (err[0]),
    .m1_cyc_i     (cyc[1]),
    .m1_stb_i     (stb[1]),
    .m1_we_i      (we[1]),
    .m1_adr_i     (adr[1]),
    .m1_dat_i     (datW[1]),
    .m1_sel_i     (sel[1]),
    .m1_dat_o     (dout[1]),
    .m1_ack_o     (ack[1]),
    .m1_err_o     (err[1]),
    .mem_active_o (mem_active_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_dat_o    (mem_dat_o),
    .mem_sel_o    (mem_sel_o),
    .mem_dat_i    (mem_dat_i),
    .mem_ack_i    (mem_ack_i),
    .gnt_o        (gnt_o)
  );

  int passCnt = 0;
  int totalCnt = 0;

  // Reference model: who owns the SRAM, how long, and whether we are cooling down.
  xact_t mst[2];
  bit    drop[2];
  int    owner = -1;
  int    age = 0;
  bit    cool = 0;
  int    last = 1;
  int    lat = 0;
  int    forceLat = -1;

  int    ackSeen[2], errSeen[2];
  int    activeSeen = 0;
  int    errAge = -1;
  int    grantLog[$];
  int    gntTrace[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    totalCnt++;
    if (got === exp) passCnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic boundFail(input string tag);
    totalCnt++;
    $display("FAIL %s: wait bound expired at %0t", tag, $time);
  endtask

  task automatic step();
    logic [1:0] reqV;
    bit         ackIn, busyE, expAck, expErr;
    for (int i = 0; i < 2; i++) begin
      if (mst[i].valid) begin
        cyc[i] = 1'b1;   stb[i] = !drop[i];
        we[i]  = mst[i].we;  adr[i] = mst[i].adr;
        datW[i] = mst[i].dat; sel[i] = mst[i].sel;
      end else begin
        cyc[i] = 1'($urandom % 2); stb[i] = 1'b0;
        we[i]  = 1'($urandom % 2); adr[i] = $urandom;
        datW[i] = $urandom;        sel[i] = 4'($urandom);
      end
      reqV[i] = mst[i].valid && !drop[i];
    end
    busyE = (owner >= 0);
    ackIn = busyE ? (age + 1 == lat) : 1'($urandom % 2);
    mem_ack_i = ackIn;
    mem_dat_i = $urandom;
    #2;
    expAck = busyE && ackIn;
    expErr = busyE && !ackIn && reqV[owner] && (age == TO - 1);
    check("gnt",    gnt_o, busyE ? (owner == 0 ? 2'b01 : 2'b10) : 2'b00);
    check("active", mem_active_o, busyE);
    check("ack0",   ack[0], expAck && owner == 0);
    check("ack1",   ack[1], expAck && owner == 1);
    check("err0",   err[0], expErr && owner == 0);
    check("err1",   err[1], expErr && owner == 1);
    check("mem_we",   mem_we_o,   busyE ? we[owner]   : 1'b0);
    check("mem_addr", mem_addr_o, busyE ? adr[owner]  : 32'h0);
    check("mem_dat",  mem_dat_o,  busyE ? datW[owner] : 32'h0);
    check("mem_sel",  mem_sel_o,  busyE ? sel[owner]  : 4'h0);
    check("dat0", dout[0], mem_dat_i);
    check("dat1", dout[1], mem_dat_i);
    for (int i = 0; i < 2; i++) begin
      if (ack[i] === 1'b1) ackSeen[i]++;
      if (err[i] === 1'b1) begin errSeen[i]++; errAge = age; end
    end
    if (mem_active_o === 1'b1) activeSeen++;
    if (busyE && age == 0) grantLog.push_back(int'(gnt_o));
    gntTrace.push_back(int'(gnt_o));
    @(posedge clk);
    #1;
    if (rst) begin
      owner = -1; age = 0; cool = 0; last = 1;
      for (int i = 0; i < 2; i++) begin mst[i].valid = 0; drop[i] = 0; end
    end else if (cool) begin
      cool = 0;
    end else if (owner < 0) begin
      if (reqV != 2'b00) begin
        owner = (reqV == 2'b11) ? (last == 0 ? 1 : 0) : (reqV[1] ? 1 : 0);
        age = 0;
        lat = (forceLat >= 0) ? forceLat : int'($urandom_range(1, 5));
      end
    end else if (expAck || expErr) begin
      last = owner; mst[owner].valid = 0; owner = -1; cool = 1;
    end else if (!reqV[owner]) begin
      mst[owner].valid = 0; drop[owner] = 0; owner = -1; cool = 1;
    end else begin
      age++;
    end
  endtask

  task automatic newXact(input int m, input bit w, input logic [31:0] a);
    mst[m].valid = 1; mst[m].we = w; mst[m].adr = a;
    mst[m].dat = $urandom; mst[m].sel = 4'($urandom);
  endtask

  task automatic clearStats();
    for (int i = 0; i < 2; i++) begin ackSeen[i] = 0; errSeen[i] = 0; end
    activeSeen = 0; errAge = -1;
    grantLog.delete(); gntTrace.delete();
  endtask

  task automatic drain();
    int n = 0;
    while ((mst[0].valid || mst[1].valid || owner >= 0 || cool) && n < 200) begin
      step(); n++;
    end
    if (n >= 200) boundFail("drain");
    step();
  endtask

  task automatic waitOwnerAge(input int who, input int a);
    int n = 0;
    while (!(owner == who && age == a) && n < 50) begin step(); n++; end
    if (n >= 50) boundFail("wait_owner");
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      cyc[i] = 0; stb[i] = 0; we[i] = 0; adr[i] = 0; datW[i] = 0; sel[i] = 0;
      mst[i].valid = 0; drop[i] = 0;
    end
    mem_ack_i = 0; mem_dat_i = 0;
    repeat (2) @(posedge clk);
    #1;
    step(); step();
    rst = 0;

    // Single m0 read with a 3-cycle controller
    clearStats(); forceLat = 3;
    newXact(0, 1'b0, 32'h100);
    drain();
    check("read_active_cycles", activeSeen, 3);
    check("read_ack_count", ackSeen[0], 1);

    // Reset on the second BUSY cycle of an m1 read
    clearStats();
    newXact(1, 1'b0, $urandom);
    waitOwnerAge(1, 1);
    rst = 1; step(); rst = 0;
    step(); step(); step(); step();
    check("rst_m1_ack", ackSeen[1], 0);
    check("rst_m1_err", errSeen[1], 0);

    // Simultaneous writes straight after reset
    clearStats(); forceLat = 2;
    newXact(0, 1'b1, $urandom);
    newXact(1, 1'b1, $urandom);
    for (int i = 0; i < 8; i++) step();
    begin
      int expTrace[8] = '{0, 1, 1, 0, 0, 2, 2, 0};
      for (int i = 0; i < 8; i++) check($sformatf("gnt_seq%0d", i), gntTrace[i], expTrace[i]);
    end
    drain();

    // Both masters requesting continuously for six transfers
    clearStats(); forceLat = -1;
    begin
      int n = 0;
      while (grantLog.size() < 6 && n < 200) begin
        for (int m = 0; m < 2; m++) if (!mst[m].valid) newXact(m, 1'($urandom % 2), $urandom);
        step(); n++;
      end
      if (n >= 200) boundFail("fairness");
      for (int i = 0; i < grantLog.size() && i < 6; i++)
        check($sformatf("rr_grant%0d", i), grantLog[i], (i % 2) ? 2 : 1);
    end
    drain();

    // Controller never acks
    clearStats(); forceLat = 99;
    newXact(0, 1'b0, $urandom);
    drain();
    check("to_err_count", errSeen[0], 1);
    check("to_ack_count", ackSeen[0], 0);
    check("to_err_age", errAge, TO - 1);
    check("to_active_cycles", activeSeen, TO);

    // m0 withdraws mid-transfer while m1 waits
    clearStats();
    newXact(0, 1'b0, $urandom);
    waitOwnerAge(0, 1);
    forceLat = 2;
    newXact(1, 1'b0, $urandom);
    drop[0] = 1;
    drain();
    check("abort_m0_ack", ackSeen[0], 0);
    check("abort_m0_err", errSeen[0], 0);
    check("abort_m1_ack", ackSeen[1], 1);

    // Random traffic, latency 1..5 so timeouts and ack-at-timeout both occur
    forceLat = -1;
    for (int c = 0; c < 600; c++) begin
      for (int m = 0; m < 2; m++)
        if (!mst[m].valid && ($urandom % 3 == 0)) newXact(m, 1'($urandom % 2), $urandom);
      step();
    end
    drain();

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
